pe_row_ctrl: RTL and testbench
==============================

PE_ROW_CTRL -- requirements
Module: pe_row_ctrl

Interface
REQ-001 SHALL have parameter INWIDTH, default 16, data width of pixels, weights and psums (Q4.12).
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum ifmap row length; counters are $clog2(MAX_LEN+1) bits wide.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_valid / cfg_ready  input / output  1  configuration handshake.
REQ-006 cfg_len  input  $clog2(MAX_LEN+1)  ifmap row length in pixels.
REQ-007 cfg_w0, cfg_w1, cfg_w2  input  INWIDTH  filter-row weights.
REQ-008 if_valid / if_ready / if_data  in / out / in  1/1/INWIDTH  ifmap pixel stream.
REQ-009 ps_in_valid / ps_in_ready / ps_in_data  in / out / in  1/1/INWIDTH  upstream psum stream.
REQ-010 ps_out_valid / ps_out_ready / ps_out_data  out / in / out  1/1/INWIDTH  accumulated psum stream.
REQ-011 mac_a0..a2, mac_b0..b2  output  INWIDTH  operands to the external 3-tap vector_mult (a = window, b = weights).
REQ-012 mac_res  input  INWIDTH  combinational dot product returned by vector_mult.
REQ-013 busy  output  1  high in any state except IDLE; done  output  1  one-cycle pulse at row completion.

Function
REQ-014 FSM states IDLE, RUN, DRAIN; cfg_ready = 1 only in IDLE.
REQ-015 IDLE: on cfg_valid&cfg_ready latch weights and len, clear window count win_cnt, pixel count pix_cnt and output count out_cnt, go RUN.
REQ-016 Latched len SHALL be clamped to [3, MAX_LEN].
REQ-017 Window: 3-entry shift register, entry 0 oldest; mac_a0..a2 = entries 0..2; mac_b0..b2 = latched weights.
REQ-018 fire = RUN & win_cnt==3 & ps_in_valid & (!ps_out_valid | ps_out_ready).
REQ-019 ps_in_ready = fire (combinational); no other cycle consumes ps_in.
REQ-020 if_ready = RUN & pix_cnt<len & (win_cnt<3 | fire).
REQ-021 On fire: ps_out_data <= mac_res + ps_in_data (INWIDTH bits, wrap), ps_out_valid <= 1, window drops entry 0, out_cnt increments.
REQ-022 Pixel accept with fire in the same cycle: shift and append happen together, win_cnt stays 3; sustained throughput one psum per cycle.
REQ-023 ps_out_valid clears on ps_out_ready handshake unless a new fire occurs that cycle.
REQ-024 When the fire making out_cnt == len-2 occurs, go DRAIN; DRAIN holds until ps_out handshake, then IDLE with done=1 for that one cycle.
REQ-025 ps_out_data SHALL stay stable while ps_out_valid & !ps_out_ready.
REQ-026 Pixels beyond len are never accepted; cfg_valid outside IDLE is ignored.

Reset
REQ-027 rst asserted at any time (including mid-row) SHALL force IDLE, clear counters, window, weights, ps_out_data to 0, and all valid/ready/busy/done outputs to 0 (cfg_ready 1 after rst deasserts).

Configuration
REQ-028 Macro PE_ROW_SAT_EN defined: the REQ-021 add SHALL saturate as signed to 16'h7FFF / 16'h8000; undefined: two's-complement wrap.

Structure
REQ-029 Package pe_pkg SHALL hold the FSM state enum, INWIDTH and FRAC=12 constants.
REQ-030 Window SHALL be a sub-module pe_row_window (shift, append, win_cnt); vector_mult is instantiated outside this block.

Verification
REQ-031 len=4, weights 0x1000 x3, pixels 0x1000,0x2000,0x3000,0x4000, ps_in 0,0 -> ps_out 0x6000 then 0x9000, done one cycle after second handshake.
REQ-032 len=8, all valids high, ps_out_ready high -> 6 outputs on 6 consecutive cycles after window fill.
REQ-033 ps_out_ready low 5 cycles mid-row -> ps_out_data stable, if_ready/ps_in_ready low once window full, no data lost.
REQ-034 ps_in 0x7F00, mac_res 0x1000 -> 0x7FFF with PE_ROW_SAT_EN, 0x8F00 without.
REQ-035 rst pulsed after 3rd output of len=8 row -> all outputs at reset values; new cfg len=3 completes with one correct output.
REQ-036 cfg_len=1 and cfg_len=MAX_LEN+5 -> clamped to 3 and MAX_LEN output counts respectively.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and FSM state encoding for the processing-element row controller.
package pe_pkg;

  localparam int INWIDTH = 16;
  localparam int FRAC    = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/pe_row_window.sv
// Three-entry sliding pixel window (entry 0 oldest) with fill count.
module pe_row_window import pe_pkg::*; #(
  parameter int W = INWIDTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] win0_o,
  output logic [W-1:0] win1_o,
  output logic [W-1:0] win2_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] e0_q, e1_q, e2_q;
  logic [1:0]   cnt_q;

  // Push fills the next free slot; shift drops the oldest; both together slide by one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      e2_q  <= '0;
      cnt_q <= 2'd0;
    end else if (clear_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      e2_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({shift_i, push_i})
        2'b01: begin
          case (cnt_q)
            2'd0:    e0_q <= data_i;
            2'd1:    e1_q <= data_i;
            default: e2_q <= data_i;
          endcase
          cnt_q <= cnt_q + 2'd1;
        end
        2'b10: begin
          e0_q  <= e1_q;
          e1_q  <= e2_q;
          e2_q  <= '0;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          e0_q <= e1_q;
          e1_q <= e2_q;
          e2_q <= data_i;
        end
        default: ;
      endcase
    end
  end

  assign win0_o = e0_q;
  assign win1_o = e1_q;
  assign win2_o = e2_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/pe_row_ctrl.sv
// Row controller for a 3-tap conv PE: slides a pixel window, accumulates psums.
// Define PE_ROW_SAT_EN for signed-saturating psum accumulation (default wraps).
module pe_row_ctrl import pe_pkg::*; #(
  parameter int  INWIDTH = pe_pkg::INWIDTH,
  parameter int  MAX_LEN = 16,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [CW-1:0]      cfg_len_i,
  input  logic [INWIDTH-1:0] cfg_w0_i,
  input  logic [INWIDTH-1:0] cfg_w1_i,
  input  logic [INWIDTH-1:0] cfg_w2_i,
  input  logic               if_valid_i,
  output logic               if_ready_o,
  input  logic [INWIDTH-1:0] if_data_i,
  input  logic               ps_in_valid_i,
  output logic               ps_in_ready_o,
  input  logic [INWIDTH-1:0] ps_in_data_i,
  output logic               ps_out_valid_o,
  input  logic               ps_out_ready_i,
  output logic [INWIDTH-1:0] ps_out_data_o,
  output logic [INWIDTH-1:0] mac_a0_o,
  output logic [INWIDTH-1:0] mac_a1_o,
  output logic [INWIDTH-1:0] mac_a2_o,
  output logic [INWIDTH-1:0] mac_b0_o,
  output logic [INWIDTH-1:0] mac_b1_o,
  output logic [INWIDTH-1:0] mac_b2_o,
  input  logic [INWIDTH-1:0] mac_res_i,
  output logic               busy_o,
  output logic               done_o
);

  state_e               state_q;
  logic                 cfg_ready_q, busy_q, done_q;
  logic [CW-1:0]        len_q, len_d, pix_cnt_q, out_cnt_q;
  logic [INWIDTH-1:0]   w0_q, w1_q, w2_q;
  logic                 ps_out_valid_q;
  logic [INWIDTH-1:0]   ps_out_data_q, sum_d;
  logic [1:0]           win_cnt;
  logic                 run, fire, pix_take, out_hs, cfg_hs;

  assign run      = (state_q == ST_RUN);
  assign fire     = run & (win_cnt == 2'd3) & ps_in_valid_i & (~ps_out_valid_q | ps_out_ready_i);
  assign if_ready_o    = run & (pix_cnt_q < len_q) & ((win_cnt != 2'd3) | fire);
  assign ps_in_ready_o = fire;
  assign pix_take = if_valid_i & if_ready_o;
  assign out_hs   = ps_out_valid_q & ps_out_ready_i;
  assign cfg_hs   = cfg_valid_i & cfg_ready_q;

  pe_row_window #(.W(INWIDTH)) u_window (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (cfg_hs),
    .push_i  (pix_take),
    .shift_i (fire),
    .data_i  (if_data_i),
    .win0_o  (mac_a0_o),
    .win1_o  (mac_a1_o),
    .win2_o  (mac_a2_o),
    .cnt_o   (win_cnt)
  );

  // Row length clamped so every row produces at least one psum.
  always_comb begin
    len_d = cfg_len_i;
    if (cfg_len_i < CW'(3)) begin
      len_d = CW'(3);
    end else if (cfg_len_i > CW'(MAX_LEN)) begin
      len_d = CW'(MAX_LEN);
    end else begin
      len_d = cfg_len_i;
    end
  end

`ifdef PE_ROW_SAT_EN
  logic [INWIDTH:0] sum_ext;

  // Signed add with clamp to the most positive / most negative code.
  always_comb begin
    sum_ext = {mac_res_i[INWIDTH-1], mac_res_i} + {ps_in_data_i[INWIDTH-1], ps_in_data_i};
    if (sum_ext[INWIDTH] != sum_ext[INWIDTH-1]) begin
      sum_d = sum_ext[INWIDTH] ? {1'b1, {(INWIDTH-1){1'b0}}} : {1'b0, {(INWIDTH-1){1'b1}}};
    end else begin
      sum_d = sum_ext[INWIDTH-1:0];
    end
  end
`else
  // Two's-complement wrap-around accumulation.
  always_comb begin
    sum_d = mac_res_i + ps_in_data_i;
  end
`endif

  // Control FSM plus the registered psum output stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cfg_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      len_q          <= '0;
      pix_cnt_q      <= '0;
      out_cnt_q      <= '0;
      w0_q           <= '0;
      w1_q           <= '0;
      w2_q           <= '0;
      ps_out_valid_q <= 1'b0;
      ps_out_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_hs) begin
            len_q       <= len_d;
            w0_q        <= cfg_w0_i;
            w1_q        <= cfg_w1_i;
            w2_q        <= cfg_w2_i;
            pix_cnt_q   <= '0;
            out_cnt_q   <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_RUN;
          end else begin
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (pix_take) pix_cnt_q <= pix_cnt_q + CW'(1);
          if (fire) begin
            out_cnt_q <= out_cnt_q + CW'(1);
            if (out_cnt_q + CW'(1) == len_q - CW'(2)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_hs) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
      endcase

      // A new fire always reloads; data otherwise holds while stalled.
      if (fire) begin
        ps_out_valid_q <= 1'b1;
        ps_out_data_q  <= sum_d;
      end else if (out_hs) begin
        ps_out_valid_q <= 1'b0;
      end
    end
  end

  assign cfg_ready_o    = cfg_ready_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign ps_out_valid_o = ps_out_valid_q;
  assign ps_out_data_o  = ps_out_data_q;
  assign mac_b0_o       = w0_q;
  assign mac_b1_o       = w1_q;
  assign mac_b2_o       = w2_q;

endmodule

// File: tb/tb_pe_row_ctrl.sv
// Directed bench for pe_row_ctrl with a behavioural Q4.12 3-tap dot product.
module tb_pe_row_ctrl;
  import pe_pkg::*;

  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready;
  logic [CW-1:0] cfg_len;
  logic [W-1:0]  cfg_w0, cfg_w1, cfg_w2;
  logic          if_valid, if_ready, ps_in_valid, ps_in_ready, ps_out_valid, ps_out_ready;
  logic [W-1:0]  if_data, ps_in_data, ps_out_data;
  logic [W-1:0]  mac_a0, mac_a1, mac_a2, mac_b0, mac_b1, mac_b2, mac_res;
  logic          busy, done;
  logic          mac_ovr_en;
  logic [W-1:0]  mac_ovr;

  always #5 clk = ~clk;

  pe_row_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_len_i(cfg_len),
    .cfg_w0_i(cfg_w0), .cfg_w1_i(cfg_w1), .cfg_w2_i(cfg_w2),
    .if_valid_i(if_valid), .if_ready_o(if_ready), .if_data_i(if_data),
    .ps_in_valid_i(ps_in_valid), .ps_in_ready_o(ps_in_ready), .ps_in_data_i(ps_in_data),
    .ps_out_valid_o(ps_out_valid), .ps_out_ready_i(ps_out_ready), .ps_out_data_o(ps_out_data),
    .mac_a0_o(mac_a0), .mac_a1_o(mac_a1), .mac_a2_o(mac_a2),
    .mac_b0_o(mac_b0), .mac_b1_o(mac_b1), .mac_b2_o(mac_b2),
    .mac_res_i(mac_res), .busy_o(busy), .done_o(done)
  );

  function automatic logic [W-1:0] dot3(input logic [W-1:0] a0, a1, a2, b0, b1, b2);
    logic signed [31:0] s0, s1, s2;
    s0 = $signed({{16{a0[15]}}, a0}) * $signed({{16{b0[15]}}, b0});
    s1 = $signed({{16{a1[15]}}, a1}) * $signed({{16{b1[15]}}, b1});
    s2 = $signed({{16{a2[15]}}, a2}) * $signed({{16{b2[15]}}, b2});
    return W'((s0 >>> FRAC) + (s1 >>> FRAC) + (s2 >>> FRAC));
  endfunction

  always_comb begin
    mac_res = mac_ovr_en ? mac_ovr : dot3(mac_a0, mac_a1, mac_a2, mac_b0, mac_b1, mac_b2);
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [W-1:0] pix_q[$];
  logic [W-1:0] ps_q[$];
  logic [W-1:0] out_q[$];
  int out_cyc[$];
  int done_cyc, stall_from, stall_to, stall_seen, stab_err, rdy_err, pix_taken;

  task automatic do_cfg(input logic [CW-1:0] len, input logic [W-1:0] w0, w1, w2, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = len; cfg_w0 = w0; cfg_w1 = w1; cfg_w2 = w2;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (cfg_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Streams pix_q/ps_q with valids held high; records outputs and stall behaviour.
  task automatic stream_row(input int budget, input int stop_outs);
    int pi = 0;
    int si = 0;
    logic [W-1:0] held = '0;
    bit hv = 1'b0;
    out_q.delete(); out_cyc.delete();
    done_cyc = -1; stall_seen = 0; stab_err = 0; rdy_err = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if_valid     = (pi < pix_q.size());
      if_data      = if_valid ? pix_q[pi] : 16'h0000;
      ps_in_valid  = (si < ps_q.size());
      ps_in_data   = ps_in_valid ? ps_q[si] : 16'h0000;
      ps_out_ready = !(c >= stall_from && c <= stall_to);
      #1;
      if (done) begin done_cyc = c; break; end
      if (ps_out_valid && !ps_out_ready) begin
        stall_seen++;
        if (hv && ps_out_data !== held) stab_err++;
        if (if_ready || ps_in_ready) rdy_err++;
        held = ps_out_data; hv = 1'b1;
      end else begin
        hv = 1'b0;
      end
      if (ps_out_valid && ps_out_ready) begin out_q.push_back(ps_out_data); out_cyc.push_back(c); end
      if (if_valid && if_ready) pi++;
      if (ps_in_valid && ps_in_ready) si++;
      if (stop_outs > 0 && out_q.size() >= stop_outs) break;
    end
    pix_taken = pi;
    if_valid = 1'b0; ps_in_valid = 1'b0; ps_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if ({cfg_ready, busy, done, ps_out_valid, if_ready, ps_in_ready} !== 6'b0) begin
      err_cnt++; $display("FAIL reset_flags got %b want 000000", {cfg_ready, busy, done, ps_out_valid, if_ready, ps_in_ready}); end
    vec_cnt++; if (ps_out_data !== 16'h0000) begin err_cnt++; $display("FAIL reset_data got %h want 0000", ps_out_data); end
    rst = 1'b0;
    @(negedge clk); #1;
    vec_cnt++; if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    do_cfg(5'd4, 16'h1000, 16'h1000, 16'h1000, ok);
    vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL basic_cfg got %b want 1", ok); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy got %b want 1", busy); end
    pix_q = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    ps_q  = '{16'h0000, 16'h0000};
    stream_row(60, 0);
    vec_cnt++; if (out_q.size() !== 2) begin err_cnt++; $display("FAIL basic_count got %0d want 2", out_q.size()); end
    vec_cnt++; if (out_q[0] !== 16'h6000) begin err_cnt++; $display("FAIL basic_out0 got %h want 6000", out_q[0]); end
    vec_cnt++; if (out_q[1] !== 16'h9000) begin err_cnt++; $display("FAIL basic_out1 got %h want 9000", out_q[1]); end
    vec_cnt++; if (done_cyc !== out_cyc[1] + 1) begin
      err_cnt++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, out_cyc[1] + 1); end
    vec_cnt++; if ({busy, cfg_ready} !== 2'b01) begin err_cnt++; $display("FAIL basic_idle got %b want 01", {busy, cfg_ready}); end
  endtask

  task automatic load_len8();
    pix_q.delete(); ps_q.delete();
    for (int i = 0; i < 8; i++) pix_q.push_back(W'((i + 1) * 256));
    for (int j = 0; j < 6; j++) ps_q.push_back(W'(j));
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_cfg(5'd8, 16'h1000, 16'h1000, 16'h1000, ok);
    load_len8();
    stream_row(80, 0);
    vec_cnt++; if (out_q.size() !== 6) begin err_cnt++; $display("FAIL b2b_count got %0d want 6", out_q.size()); end
    for (int j = 0; j < 6; j++) begin
      vec_cnt++; if (out_q[j] !== W'((3 * j + 6) * 256 + j)) begin
        err_cnt++; $display("FAIL b2b_out%0d got %h want %h", j, out_q[j], W'((3 * j + 6) * 256 + j)); end
    end
    for (int j = 1; j < 6; j++) begin
      vec_cnt++; if (out_cyc[j] !== out_cyc[0] + j) begin
        err_cnt++; $display("FAIL b2b_cycle%0d got %0d want %0d", j, out_cyc[j], out_cyc[0] + j); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_cfg(5'd8, 16'h1000, 16'h1000, 16'h1000, ok);
    load_len8();
    stall_from = 6; stall_to = 10;
    stream_row(80, 0);
    stall_from = -1; stall_to = -1;
    vec_cnt++; if (stall_seen !== 5) begin err_cnt++; $display("FAIL stall_cycles got %0d want 5", stall_seen); end
    vec_cnt++; if (stab_err !== 0) begin err_cnt++; $display("FAIL stall_data_stable got %0d changes want 0", stab_err); end
    vec_cnt++; if (rdy_err !== 0) begin err_cnt++; $display("FAIL stall_readies got %0d high cycles want 0", rdy_err); end
    vec_cnt++; if (out_q.size() !== 6) begin err_cnt++; $display("FAIL stall_count got %0d want 6", out_q.size()); end
    vec_cnt++; if (out_q[2] !== 16'h0C02 || out_q[5] !== 16'h1505) begin
      err_cnt++; $display("FAIL stall_values got %h/%h want 0c02/1505", out_q[2], out_q[5]); end
  endtask

  task automatic test_sat();
    bit ok;
    logic [W-1:0] exp;
`ifdef PE_ROW_SAT_EN
    exp = 16'h7FFF;
`else
    exp = 16'h8F00;
`endif
    mac_ovr_en = 1'b1; mac_ovr = 16'h1000;
    do_cfg(5'd3, 16'h1000, 16'h1000, 16'h1000, ok);
    pix_q = '{16'h0001, 16'h0002, 16'h0003};
    ps_q  = '{16'h7F00};
    stream_row(40, 0);
    mac_ovr_en = 1'b0;
    vec_cnt++; if (out_q.size() !== 1 || out_q[0] !== exp) begin
      err_cnt++; $display("FAIL sat_add got %h (n=%0d) want %h", out_q[0], out_q.size(), exp); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_cfg(5'd8, 16'h1000, 16'h1000, 16'h1000, ok);
    load_len8();
    stream_row(80, 3);
    vec_cnt++; if (out_q.size() !== 3) begin err_cnt++; $display("FAIL rst_pre_count got %0d want 3", out_q.size()); end
    rst = 1'b1;
    #1;
    vec_cnt++; if ({cfg_ready, busy, done, ps_out_valid, if_ready, ps_in_ready} !== 6'b0) begin
      err_cnt++; $display("FAIL rst_mid_flags got %b want 000000", {cfg_ready, busy, done, ps_out_valid, if_ready, ps_in_ready}); end
    vec_cnt++; if ({ps_out_data, mac_a0, mac_a2, mac_b0} !== 64'h0) begin
      err_cnt++; $display("FAIL rst_mid_data got %h want 0", {ps_out_data, mac_a0, mac_a2, mac_b0}); end
    @(negedge clk);
    rst = 1'b0;
    do_cfg(5'd3, 16'h1000, 16'h1000, 16'h1000, ok);
    vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL rst_recfg got %b want 1", ok); end
    pix_q = '{16'h0100, 16'h0200, 16'h0300};
    ps_q  = '{16'h0005};
    stream_row(40, 0);
    vec_cnt++; if (out_q.size() !== 1 || out_q[0] !== 16'h0605) begin
      err_cnt++; $display("FAIL rst_len3 got %h (n=%0d) want 0605", out_q[0], out_q.size()); end
  endtask

  task automatic test_clamp();
    bit ok;
    do_cfg(5'd1, 16'h1000, 16'h1000, 16'h1000, ok);
    pix_q.delete(); ps_q.delete();
    for (int i = 0; i < 5; i++) begin pix_q.push_back(16'h0100); ps_q.push_back(16'h0000); end
    stream_row(40, 0);
    vec_cnt++; if (out_q.size() !== 1 || pix_taken !== 3) begin
      err_cnt++; $display("FAIL clamp_low got %0d outs %0d pix want 1 outs 3 pix", out_q.size(), pix_taken); end
    do_cfg(5'd21, 16'h1000, 16'h1000, 16'h1000, ok);
    pix_q.delete(); ps_q.delete();
    for (int i = 0; i < 20; i++) begin pix_q.push_back(16'h0100); ps_q.push_back(16'h0000); end
    stream_row(100, 0);
    vec_cnt++; if (out_q.size() !== 14 || pix_taken !== 16) begin
      err_cnt++; $display("FAIL clamp_high got %0d outs %0d pix want 14 outs 16 pix", out_q.size(), pix_taken); end
    vec_cnt++; if (done_cyc < 0) begin err_cnt++; $display("FAIL clamp_high_done got %0d want >=0", done_cyc); end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0; cfg_w0 = '0; cfg_w1 = '0; cfg_w2 = '0;
    if_valid = 1'b0; if_data = '0; ps_in_valid = 1'b0; ps_in_data = '0; ps_out_ready = 1'b1;
    mac_ovr_en = 1'b0; mac_ovr = '0; stall_from = -1; stall_to = -1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_sat();
    test_mid_reset();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
